// File: rtl/kbdmus_spi_rx.sv
// SPI mode-0 slave that decodes MCU keyboard/mouse/joystick frames into strobed bytes.
// All SPI pins are resynchronised to fclk; fclk must run at least 4x SCK.
module kbdmus_spi_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       fclk,
    input  logic       rst_n,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    input  logic       spi_cs_n,
    output logic [7:0] kbd_in,
    output logic [2:0] kbd_in_sel,
    output logic       kbd_stb,
    output logic [7:0] mus_in,
    output logic       mus_xstb,
    output logic       mus_ystb,
    output logic       mus_btnstb,
    output logic       kj_stb,
    output logic       frame_err
);

    typedef enum logic [2:0] {StIdle, StCmd, StKbd, StMus, StSkip} state_e;

    logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, cs_sync_q, vld_q;
    logic       sck_s, mosi_s, cs_s, rise, fall, shift_en;
    logic       sck_prev_q, cs_prev_q, cs_prev_d;
    state_e     state_q, state_d, state_nb;
    logic [2:0] bitcnt_q, bitcnt_d, idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic       byte_vld_q, byte_vld_d;
    logic [1:0] tgt_q, tgt_d;
    logic [7:0] kbd_in_q, kbd_in_d, mus_in_q, mus_in_d;
    logic [2:0] kbd_sel_q, kbd_sel_d;
    logic       kbd_stb_q, kbd_stb_d, xstb_q, xstb_d, ystb_q, ystb_d;
    logic       btnstb_q, btnstb_d, kjstb_q, kjstb_d, err_q, err_d;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];

    // cs_prev only holds a genuine high once the synchroniser has refilled after
    // reset, so a cs_n held low across reset is not mistaken for a new frame.
    assign cs_prev_d = vld_q[SYNC_STAGES-1] ? cs_s : 1'b0;
    assign fall      = cs_prev_q & ~cs_s;
    assign rise      = sck_s & ~sck_prev_q & ~cs_s;
    assign shift_en  = rise & (state_q != StIdle);

    always_comb begin
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        byte_vld_d = 1'b0;
        if (cs_s || state_q == StIdle) begin
            bitcnt_d = 3'd0;
            shift_d  = 8'd0;
        end else if (shift_en) begin
            bitcnt_d   = bitcnt_q + 3'd1;
            shift_d    = {shift_q[6:0], mosi_s};
            byte_vld_d = (bitcnt_q == 3'd7);
        end
    end

    always_comb begin
        state_nb  = state_q;
        idx_d     = idx_q;
        tgt_d     = tgt_q;
        kbd_in_d  = kbd_in_q;
        kbd_sel_d = kbd_sel_q;
        mus_in_d  = mus_in_q;
        kbd_stb_d = 1'b0;
        xstb_d    = 1'b0;
        ystb_d    = 1'b0;
        btnstb_d  = 1'b0;
        kjstb_d   = 1'b0;
        err_d     = 1'b0;
        // A completed byte is always consumed before a cs_n rise is acted upon.
        if (byte_vld_q) begin
            unique case (state_q)
                StCmd: begin
                    if (shift_q == 8'h01) begin
                        state_nb = StKbd;
                        idx_d    = 3'd0;
                    end else if (shift_q >= 8'h0A && shift_q <= 8'h0D) begin
                        state_nb = StMus;
                        tgt_d    = shift_q[1:0] + 2'd2;
                    end else begin
                        state_nb = StSkip;
                    end
                end
                StKbd: begin
                    kbd_in_d  = shift_q;
                    kbd_sel_d = idx_q;
                    kbd_stb_d = 1'b1;
                    idx_d     = idx_q + 3'd1;
                    if (idx_q == 3'd4) state_nb = StSkip;
                end
                StMus: begin
                    mus_in_d = shift_q;
                    xstb_d   = (tgt_q == 2'd0);
                    ystb_d   = (tgt_q == 2'd1);
                    btnstb_d = (tgt_q == 2'd2);
                    kjstb_d  = (tgt_q == 2'd3);
                    state_nb = StSkip;
                end
                default: ;
            endcase
        end
        state_d = state_nb;
        if (cs_s) begin
            if (state_q != StIdle) begin
                err_d = (bitcnt_q != 3'd0) || (state_nb == StKbd) || (state_nb == StMus);
            end
            state_d = StIdle;
        end else if (state_q == StIdle && fall) begin
            state_d = StCmd;
        end
    end

    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            vld_q       <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b0;
            state_q     <= StIdle;
            bitcnt_q    <= 3'd0;
            shift_q     <= 8'd0;
            byte_vld_q  <= 1'b0;
            idx_q       <= 3'd0;
            tgt_q       <= 2'd0;
            kbd_in_q    <= 8'd0;
            kbd_sel_q   <= 3'd0;
            mus_in_q    <= 8'd0;
            kbd_stb_q   <= 1'b0;
            xstb_q      <= 1'b0;
            ystb_q      <= 1'b0;
            btnstb_q    <= 1'b0;
            kjstb_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sck_sync_q  <= (sck_sync_q << 1) | SYNC_STAGES'(spi_sck);
            mosi_sync_q <= (mosi_sync_q << 1) | SYNC_STAGES'(spi_mosi);
            cs_sync_q   <= (cs_sync_q << 1) | SYNC_STAGES'(spi_cs_n);
            vld_q       <= (vld_q << 1) | SYNC_STAGES'(1);
            sck_prev_q  <= sck_s;
            cs_prev_q   <= cs_prev_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            byte_vld_q  <= byte_vld_d;
            idx_q       <= idx_d;
            tgt_q       <= tgt_d;
            kbd_in_q    <= kbd_in_d;
            kbd_sel_q   <= kbd_sel_d;
            mus_in_q    <= mus_in_d;
            kbd_stb_q   <= kbd_stb_d;
            xstb_q      <= xstb_d;
            ystb_q      <= ystb_d;
            btnstb_q    <= btnstb_d;
            kjstb_q     <= kjstb_d;
            err_q       <= err_d;
        end
    end

    assign kbd_in     = kbd_in_q;
    assign kbd_in_sel = kbd_sel_q;
    assign kbd_stb    = kbd_stb_q;
    assign mus_in     = mus_in_q;
    assign mus_xstb   = xstb_q;
    assign mus_ystb   = ystb_q;
    assign mus_btnstb = btnstb_q;
    assign kj_stb     = kjstb_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_kbdmus_spi_rx.sv
// Directed bench for kbdmus_spi_rx: drives SPI frames and checks the logged strobe events.
module tb_kbdmus_spi_rx;

    logic       fclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_sck = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic [7:0] kbd_in, mus_in;
    logic [2:0] kbd_in_sel;
    logic       kbd_stb, mus_xstb, mus_ystb, mus_btnstb, kj_stb, frame_err;

    int checks = 0;
    int failures = 0;
    int err_cnt = 0;
    int multi_cnt = 0;
    logic [15:0] ev_q[$];

    kbdmus_spi_rx #(.SYNC_STAGES(2)) dut (
        .fclk       (fclk),
        .rst_n      (rst_n),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_cs_n   (spi_cs_n),
        .kbd_in     (kbd_in),
        .kbd_in_sel (kbd_in_sel),
        .kbd_stb    (kbd_stb),
        .mus_in     (mus_in),
        .mus_xstb   (mus_xstb),
        .mus_ystb   (mus_ystb),
        .mus_btnstb (mus_btnstb),
        .kj_stb     (kj_stb),
        .frame_err  (frame_err)
    );

    always #5 fclk = ~fclk;

    // Event kinds: 0 kbd, 1 x, 2 y, 3 btn, 4 kj; packed as {kind, sel, data}.
    function automatic logic [15:0] ev(input int kind, input int sel, input logic [7:0] d);
        return {kind[3:0], sel[3:0], d};
    endfunction

    always @(negedge fclk) begin
        int n;
        n = int'(kbd_stb) + int'(mus_xstb) + int'(mus_ystb) + int'(mus_btnstb) + int'(kj_stb);
        if (n > 1) multi_cnt++;
        if (kbd_stb)    ev_q.push_back(ev(0, int'(kbd_in_sel), kbd_in));
        if (mus_xstb)   ev_q.push_back(ev(1, 0, mus_in));
        if (mus_ystb)   ev_q.push_back(ev(2, 0, mus_in));
        if (mus_btnstb) ev_q.push_back(ev(3, 0, mus_in));
        if (kj_stb)     ev_q.push_back(ev(4, 0, mus_in));
        if (frame_err)  err_cnt++;
    end

    task automatic clear_log();
        ev_q.delete();
        err_cnt = 0;
    endtask

    task automatic spi_bit(input logic b);
        spi_mosi = b;
        #40 spi_sck = 1'b1;
        #40 spi_sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    endtask

    task automatic frame_start();
        spi_cs_n = 1'b0;
        #60;
    endtask

    task automatic frame_end();
        #60 spi_cs_n = 1'b1;
        #200;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(posedge fclk);
        #1;
        checks++;
        if ({kbd_in, kbd_in_sel, mus_in} !== 19'd0) begin
            failures++;
            $display("FAIL reset_data: got %h want 0", {kbd_in, kbd_in_sel, mus_in});
        end
        checks++;
        if ({kbd_stb, mus_xstb, mus_ystb, mus_btnstb, kj_stb, frame_err} !== 6'd0) begin
            failures++;
            $display("FAIL reset_strobes: got %b want 000000",
                     {kbd_stb, mus_xstb, mus_ystb, mus_btnstb, kj_stb, frame_err});
        end
        #1 rst_n = 1'b1;
        repeat (10) @(posedge fclk);
        #2;
        checks++;
        if (ev_q.size() != 0 || err_cnt != 0) begin
            failures++;
            $display("FAIL reset_idle: got events=%0d errs=%0d want 0 0", ev_q.size(), err_cnt);
        end
    endtask

    task automatic test_kbd_frame();
        logic [15:0] exp_q[$];
        clear_log();
        frame_start();
        spi_byte(8'h01);
        for (int i = 1; i <= 5; i++) spi_byte({4'(i), 4'(i)});
        frame_end();
        for (int i = 0; i < 5; i++) exp_q.push_back(ev(0, i, {4'(i + 1), 4'(i + 1)}));
        checks++;
        if (ev_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL kbd_count: got %0d want %0d", ev_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            checks++;
            if (ev_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL kbd_ev%0d: got %h want %h", i, ev_q[i], exp_q[i]);
            end
        end
        checks++;
        if (err_cnt != 0) begin
            failures++;
            $display("FAIL kbd_err: got %0d want 0", err_cnt);
        end
        checks++;
        if (kbd_in !== 8'h55 || kbd_in_sel !== 3'd4) begin
            failures++;
            $display("FAIL kbd_hold: got %h/%0d want 55/4", kbd_in, kbd_in_sel);
        end
    endtask

    task automatic test_mus_frames();
        logic [7:0] cmd[4] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
        logic [7:0] dat[4] = '{8'h7F, 8'h80, 8'hF5, 8'h1F};
        clear_log();
        for (int i = 0; i < 4; i++) begin
            frame_start();
            spi_byte(cmd[i]);
            spi_byte(dat[i]);
            frame_end();
        end
        checks++;
        if (ev_q.size() != 4) begin
            failures++;
            $display("FAIL mus_count: got %0d want 4", ev_q.size());
        end
        for (int i = 0; i < 4 && i < ev_q.size(); i++) begin
            checks++;
            if (ev_q[i] !== ev(i + 1, 0, dat[i])) begin
                failures++;
                $display("FAIL mus_ev%0d: got %h want %h", i, ev_q[i], ev(i + 1, 0, dat[i]));
            end
        end
        checks++;
        if (err_cnt != 0 || mus_in !== 8'h1F) begin
            failures++;
            $display("FAIL mus_err_hold: got err=%0d mus_in=%h want 0 1f", err_cnt, mus_in);
        end
    endtask

    task automatic test_kbd_short();
        clear_log();
        frame_start();
        spi_byte(8'h01);
        spi_byte(8'hAA);
        spi_byte(8'hBB);
        frame_end();
        checks++;
        if (ev_q.size() != 2) begin
            failures++;
            $display("FAIL short_count: got %0d want 2", ev_q.size());
        end else begin
            checks++;
            if (ev_q[0] !== ev(0, 0, 8'hAA) || ev_q[1] !== ev(0, 1, 8'hBB)) begin
                failures++;
                $display("FAIL short_ev: got %h %h want %h %h", ev_q[0], ev_q[1],
                         ev(0, 0, 8'hAA), ev(0, 1, 8'hBB));
            end
        end
        checks++;
        if (err_cnt != 1) begin
            failures++;
            $display("FAIL short_err: got %0d want 1", err_cnt);
        end
        checks++;
        if (kbd_in !== 8'hBB || kbd_in_sel !== 3'd1) begin
            failures++;
            $display("FAIL short_hold: got %h/%0d want bb/1", kbd_in, kbd_in_sel);
        end
    endtask

    task automatic test_mus_partial();
        clear_log();
        frame_start();
        spi_byte(8'h0A);
        spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1); spi_bit(1'b1); spi_bit(1'b0);
        frame_end();
        checks++;
        if (ev_q.size() != 0 || err_cnt != 1) begin
            failures++;
            $display("FAIL partial: got events=%0d errs=%0d want 0 1", ev_q.size(), err_cnt);
        end
        clear_log();
        frame_start();
        spi_byte(8'h0B);
        spi_byte(8'h42);
        frame_end();
        checks++;
        if (ev_q.size() != 1 || err_cnt != 0) begin
            failures++;
            $display("FAIL recover_count: got events=%0d errs=%0d want 1 0", ev_q.size(), err_cnt);
        end else begin
            checks++;
            if (ev_q[0] !== ev(2, 0, 8'h42)) begin
                failures++;
                $display("FAIL recover_ev: got %h want %h", ev_q[0], ev(2, 0, 8'h42));
            end
        end
    endtask

    task automatic test_skip();
        clear_log();
        frame_start();
        spi_byte(8'h7E); spi_byte(8'h12); spi_byte(8'h34);
        frame_end();
        checks++;
        if (ev_q.size() != 0 || err_cnt != 0) begin
            failures++;
            $display("FAIL skip_unknown: got events=%0d errs=%0d want 0 0", ev_q.size(), err_cnt);
        end
        clear_log();
        frame_start();
        spi_byte(8'h0C); spi_byte(8'h01); spi_byte(8'h02);
        frame_end();
        checks++;
        if (ev_q.size() != 1 || err_cnt != 0) begin
            failures++;
            $display("FAIL skip_btn_count: got events=%0d errs=%0d want 1 0", ev_q.size(), err_cnt);
        end else begin
            checks++;
            if (ev_q[0] !== ev(3, 0, 8'h01) || mus_in !== 8'h01) begin
                failures++;
                $display("FAIL skip_btn_ev: got %h mus_in=%h want %h 01", ev_q[0], mus_in,
                         ev(3, 0, 8'h01));
            end
        end
    endtask

    // cs_n rises one fclk after the final SCK edge, then a new frame follows promptly.
    task automatic test_back_to_back();
        logic [7:0] b;
        clear_log();
        frame_start();
        spi_byte(8'h0D);
        b = 8'h5A;
        for (int i = 7; i >= 1; i--) spi_bit(b[i]);
        spi_mosi = b[0];
        #40 spi_sck = 1'b1;
        #10 spi_cs_n = 1'b1;
        #30 spi_sck = 1'b0;
        #40;
        frame_start();
        spi_byte(8'h0A);
        spi_byte(8'h33);
        frame_end();
        checks++;
        if (ev_q.size() != 2 || err_cnt != 0) begin
            failures++;
            $display("FAIL b2b_count: got events=%0d errs=%0d want 2 0", ev_q.size(), err_cnt);
        end else begin
            checks++;
            if (ev_q[0] !== ev(4, 0, 8'h5A) || ev_q[1] !== ev(1, 0, 8'h33)) begin
                failures++;
                $display("FAIL b2b_ev: got %h %h want %h %h", ev_q[0], ev_q[1],
                         ev(4, 0, 8'h5A), ev(1, 0, 8'h33));
            end
        end
    endtask

    task automatic test_reset_midframe();
        clear_log();
        frame_start();
        spi_byte(8'h01);
        spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1);
        rst_n = 1'b0;
        repeat (4) @(posedge fclk);
        #1;
        checks++;
        if ({kbd_in, kbd_in_sel, mus_in} !== 19'd0) begin
            failures++;
            $display("FAIL midrst_data: got %h want 0", {kbd_in, kbd_in_sel, mus_in});
        end
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) spi_bit(1'b1);
        frame_end();
        checks++;
        if (ev_q.size() != 0 || err_cnt != 0) begin
            failures++;
            $display("FAIL midrst_quiet: got events=%0d errs=%0d want 0 0", ev_q.size(), err_cnt);
        end
        clear_log();
        frame_start();
        for (int i = 0; i < 6; i++) spi_byte(8'h01);
        frame_end();
        checks++;
        if (ev_q.size() != 5 || err_cnt != 0) begin
            failures++;
            $display("FAIL midrst_frame: got events=%0d errs=%0d want 5 0", ev_q.size(), err_cnt);
        end
        for (int i = 0; i < 5 && i < ev_q.size(); i++) begin
            checks++;
            if (ev_q[i] !== ev(0, i, 8'h01)) begin
                failures++;
                $display("FAIL midrst_ev%0d: got %h want %h", i, ev_q[i], ev(0, i, 8'h01));
            end
        end
    endtask

    initial begin
        @(posedge fclk);
        #2;
        test_reset();
        test_kbd_frame();
        test_mus_frames();
        test_kbd_short();
        test_mus_partial();
        test_skip();
        test_back_to_back();
        test_reset_midframe();
        checks++;
        if (multi_cnt != 0) begin
            failures++;
            $display("FAIL one_hot_strobes: got %0d overlapping cycles want 0", multi_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
